// File: rtl/ps2_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Brief    : Shared types and Set-2 scan-code constants for the PS/2 decoder.
// Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    localparam int KEY_W = 9;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    localparam logic [KEY_W-1:0] KEY_SPACE = 9'h029;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    // Keyboard housekeeping replies (BAT, echo, ack, resend, error) carry no key.
    function automatic logic is_drop_code(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
               (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_frame_rx
// Brief    : PS/2 line synchronizer, clock filter and 11-bit frame receiver.
//            Optional idle-timeout abort enabled by macro PS2_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 250000
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_rdy,
    output logic       err
);

    localparam int c_FW = $clog2(FILTER_LEN + 1);

    logic [1:0]      r_clk_sync;
    logic [1:0]      r_dat_sync;
    logic            r_filt;
    logic            r_filt_d;
    logic [c_FW-1:0] r_flt_cnt;
    logic            w_sample;
    logic            w_data;
    logic            w_timeout;

    rx_state_t r_state;
    rx_state_t w_state_nxt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_par;
    logic [7:0] r_byte;
    logic       r_byte_rdy;
    logic       r_err;
    logic       w_frame_end;
    logic       w_good;
    logic       w_bad;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
        end
    end

    // The filtered level follows the line only after a full run of opposite samples.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt    <= 1'b1;
            r_filt_d  <= 1'b1;
            r_flt_cnt <= '0;
        end else begin
            r_filt_d <= r_filt;
            if (r_clk_sync[1] == r_filt) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == c_FW'(FILTER_LEN - 1)) begin
                r_filt    <= r_clk_sync[1];
                r_flt_cnt <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + c_FW'(1);
            end
        end
    end

    assign w_sample = r_filt_d & ~r_filt;
    assign w_data   = r_dat_sync[1];

`ifdef PS2_TIMEOUT_EN
    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_TW-1:0] r_idle_cnt;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
        end else if (w_sample || (r_state == IDLE)) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != c_TW'(TIMEOUT_CYCLES)) begin
            r_idle_cnt <= r_idle_cnt + c_TW'(1);
        end
    end

    assign w_timeout = (r_state != IDLE) && !w_sample &&
                       (r_idle_cnt == c_TW'(TIMEOUT_CYCLES - 1));
`else
    // Timeout logic compiled out; the comparison is a compile-time false.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_timeout) begin
            w_state_nxt = IDLE;
        end else if (w_sample) begin
            unique case (r_state)
                IDLE:    if (!w_data) w_state_nxt = DATA;
                DATA:    if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
                PARITY:  w_state_nxt = STOP;
                STOP:    w_state_nxt = IDLE;
            endcase
        end
    end

    // Odd parity over data + parity bit, stop bit must be high.
    always_comb begin
        w_frame_end = w_sample && (r_state == STOP);
        w_good      = w_frame_end && w_data && (^{r_shift, r_par});
        w_bad       = (w_frame_end && !(w_data && (^{r_shift, r_par}))) || w_timeout;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_byte     <= '0;
            r_byte_rdy <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_byte_rdy <= w_good;
            r_err      <= w_bad;
            if (w_good) begin
                r_byte <= r_shift;
            end
            if (w_sample && !w_timeout) begin
                if (r_state == IDLE) begin
                    r_bit_cnt <= '0;
                end else if (r_state == DATA) begin
                    r_shift   <= {w_data, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end else if (r_state == PARITY) begin
                    r_par <= w_data;
                end
            end
        end
    end

    assign rx_byte  = r_byte;
    assign byte_rdy = r_byte_rdy;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_key_decoder
// Brief    : Set-2 scan-code decoder with E0/F0/E1 prefix handling and a
//            512-entry key-state vector. Optional timeout via PS2_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 250000,
    parameter int SKIP_BYTES     = 7
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    output logic [511:0]     key_down,
    output logic [KEY_W-1:0] last_change,
    output logic             key_valid,
    output logic             frame_err
);

    localparam int c_SW = $clog2(SKIP_BYTES + 1);

    logic [7:0]       w_rx_byte;
    logic             w_byte_rdy;
    logic             w_rx_err;

    logic [511:0]     r_key_down;
    logic [KEY_W-1:0] r_last_change;
    logic             r_key_valid;
    logic             r_frame_err;
    logic             r_ext;
    logic             r_brk;
    logic [c_SW-1:0]  r_skip;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .pclk     (pclk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (w_rx_byte),
        .byte_rdy (w_byte_rdy),
        .err      (w_rx_err)
    );

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_down    <= '0;
            r_last_change <= '0;
            r_key_valid   <= 1'b0;
            r_frame_err   <= 1'b0;
            r_ext         <= 1'b0;
            r_brk         <= 1'b0;
            r_skip        <= '0;
        end else begin
            r_key_valid <= 1'b0;
            r_frame_err <= w_rx_err;
            if (w_rx_err) begin
                // A corrupted frame may have been the key byte, so stale prefixes are dropped.
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (w_byte_rdy) begin
                if (r_skip != '0) begin
                    r_skip <= r_skip - c_SW'(1);
                end else if (w_rx_byte == PS2_PAUSE) begin
                    r_skip <= c_SW'(SKIP_BYTES);
                end else if (w_rx_byte == PS2_EXT) begin
                    r_ext <= 1'b1;
                end else if (w_rx_byte == PS2_BRK) begin
                    r_brk <= 1'b1;
                end else if (!is_drop_code(w_rx_byte)) begin
                    r_key_down[{r_ext, w_rx_byte}] <= ~r_brk;
                    r_last_change <= {r_ext, w_rx_byte};
                    r_key_valid   <= 1'b1;
                    r_ext         <= 1'b0;
                    r_brk         <= 1'b0;
                end
            end
        end
    end

    assign key_down    = r_key_down;
    assign last_change = r_last_change;
    assign key_valid   = r_key_valid;
    assign frame_err   = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ps2_key_decoder
// Brief    : Directed + randomized bench for ps2_key_decoder with a
//            byte-level reference model. Honours PS2_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder;

    localparam int c_FILTER  = 8;
    localparam int c_TIMEOUT = 2000;
    localparam int c_SKIP    = 7;
    localparam int c_HALF    = 20;

    logic         pclk     = 1'b0;
    logic         rst_n    = 1'b0;
    logic         ps2_clk  = 1'b1;
    logic         ps2_data = 1'b1;
    logic [511:0] key_down;
    logic [8:0]   last_change;
    logic         key_valid;
    logic         frame_err;

    ps2_key_decoder #(
        .FILTER_LEN     (c_FILTER),
        .TIMEOUT_CYCLES (c_TIMEOUT),
        .SKIP_BYTES     (c_SKIP)
    ) dut (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .key_down    (key_down),
        .last_change (last_change),
        .key_valid   (key_valid),
        .frame_err   (frame_err)
    );

    always #5 pclk = ~pclk;

    int checks   = 0;
    int failures = 0;
    int kv_cnt   = 0;
    int fe_cnt   = 0;

    // Reference model state, advanced one whole byte at a time.
    logic [511:0] m_down = '0;
    logic [8:0]   m_last = '0;
    bit           m_ext  = 1'b0;
    bit           m_brk  = 1'b0;
    int           m_skip = 0;
    int           m_kv   = 0;
    int           m_fe   = 0;

    always @(posedge pclk) begin
        if (key_valid === 1'b1) kv_cnt <= kv_cnt + 1;
        if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".down"}, key_down, m_down);
        chk({tag, ".last"}, 512'(last_change), 512'(m_last));
        chk({tag, ".kvcnt"}, 512'(kv_cnt), 512'(m_kv));
        chk({tag, ".fecnt"}, 512'(fe_cnt), 512'(m_fe));
    endtask

    function automatic bit is_house(input logic [7:0] b);
        logic [7:0] lst [6] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
        foreach (lst[i]) if (lst[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_byte(input logic [7:0] b, input bit bad);
        if (bad) begin
            m_fe++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (m_skip > 0) begin
            m_skip--;
        end else if (b == 8'hE1) begin
            m_skip = c_SKIP;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (!is_house(b)) begin
            m_down[{m_ext, b}] = ~m_brk;
            m_last = {m_ext, b};
            m_kv++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    // bit0 = start, bits 1..8 = data LSB first, bit9 = odd parity, bit10 = stop
    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad);
        logic p;
        p = ~(^b) ^ bad;
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic drive_bit(input logic v);
        @(negedge pclk);
        ps2_data = v;
        repeat (c_HALF) @(negedge pclk);
        ps2_clk = 1'b0;
        repeat (c_HALF) @(negedge pclk);
        ps2_clk = 1'b1;
    endtask

    task automatic drive_bits(input logic [10:0] f, input int first, input int last);
        for (int i = first; i <= last; i++) drive_bit(f[i]);
        @(negedge pclk);
        ps2_data = 1'b1;
        repeat (c_HALF) @(negedge pclk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad);
        drive_bits(mk_frame(b, bad), 0, 10);
        model_byte(b, bad);
    endtask

    task automatic model_reset();
        m_down = '0;
        m_last = '0;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_skip = 0;
    endtask

    initial begin
        logic [7:0] pause_seq [7] = '{8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        logic [7:0] house     [6] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
        logic [10:0] f;
        int kv_before;

        // Reset state
        repeat (5) @(negedge pclk);
        chk("rst.down", key_down, '0);
        chk("rst.last", 512'(last_change), '0);
        chk("rst.kv",   512'(key_valid), '0);
        chk("rst.ferr", 512'(frame_err), '0);
        rst_n = 1'b1;
        repeat (10) @(negedge pclk);

        // Space make
        send_frame(8'h29, 1'b0);
        check_all("make29");
        chk("make29.bit", 512'(key_down[9'h029]), 512'(1));

        // Space break
        send_frame(8'hF0, 1'b0);
        send_frame(8'h29, 1'b0);
        check_all("brk29");
        chk("brk29.bit", 512'(key_down[9'h029]), 512'(0));

        // Extended make then break
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        check_all("ext75.make");
        chk("ext75.hi", 512'(key_down[9'h175]), 512'(1));
        chk("ext75.lo", 512'(key_down[9'h075]), 512'(0));
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        check_all("ext75.brk");
        chk("ext75.lo2", 512'(key_down[9'h075]), 512'(0));

        // Typematic repeat and break of a key not held
        send_frame(8'h1D, 1'b0);
        send_frame(8'h1D, 1'b0);
        check_all("repeat1D");
        send_frame(8'hF0, 1'b0);
        send_frame(8'h33, 1'b0);
        check_all("brk_not_down");

        // Housekeeping byte between break prefix and key keeps the prefix
        send_frame(8'hF0, 1'b0);
        send_frame(8'hAA, 1'b0);
        send_frame(8'h1D, 1'b0);
        check_all("drop_keeps_brk");

        // Bad parity clears a pending break; following E0 is honoured
        send_frame(8'h29, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h29, 1'b1);
        check_all("badpar");
        send_frame(8'hE0, 1'b0);
        send_frame(8'h29, 1'b0);
        check_all("after_bad");

        // Partial frame followed by silence
        send_frame(8'hF0, 1'b0);
        f = mk_frame(8'h1C, 1'b0);
        drive_bits(f, 0, 4);
`ifdef PS2_TIMEOUT_EN
        repeat (c_TIMEOUT + 100) @(negedge pclk);
        m_fe++;
        m_ext = 1'b0;
        m_brk = 1'b0;
        check_all("timeout");
`else
        repeat (c_TIMEOUT + 100) @(negedge pclk);
        check_all("no_timeout");
        drive_bits(f, 5, 10);
        model_byte(8'h1C, 1'b0);
        check_all("partial_resumed");
`endif
        send_frame(8'h1C, 1'b0);
        check_all("make1C");
        chk("make1C.bit", 512'(key_down[9'h01C]), 512'(1));

        // Pause sequence swallows seven bytes
        kv_before = kv_cnt;
        send_frame(8'hE1, 1'b0);
        foreach (pause_seq[i]) send_frame(pause_seq[i], 1'b0);
        chk("pause.nokv", 512'(kv_cnt), 512'(kv_before));
        send_frame(8'h29, 1'b0);
        check_all("after_pause");

        // Short clock glitch with data low must not start a frame
        @(negedge pclk);
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        repeat (c_FILTER - 3) @(negedge pclk);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (50) @(negedge pclk);
        send_frame(8'h2B, 1'b0);
        check_all("glitch");

        // Reset in the middle of a frame
        drive_bits(mk_frame(8'h4D, 1'b0), 0, 5);
        @(negedge pclk);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst.down", key_down, '0);
        chk("midrst.last", 512'(last_change), '0);
        repeat (5) @(negedge pclk);
        rst_n = 1'b1;
        repeat (10) @(negedge pclk);
        send_frame(8'h4D, 1'b0);
        check_all("after_rst");

        // Randomized byte stream
        for (int n = 0; n < 40; n++) begin
            int r;
            logic [7:0] b;
            bit bad;
            r   = $urandom_range(0, 99);
            bad = 1'b0;
            if (r < 12)      b = 8'hE0;
            else if (r < 25) b = 8'hF0;
            else if (r < 30) b = house[$urandom_range(0, 5)];
            else if (r < 35) begin
                b   = 8'($urandom_range(0, 255));
                bad = 1'b1;
            end else begin
                b = 8'($urandom_range(1, 8'h83));
                if (b == 8'hE0 || b == 8'hE1 || b == 8'hF0) b = 8'h16;
            end
            send_frame(b, bad);
            check_all($sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
